// File: rtl/response_encoder.sv
// Transmit side of the host UART link. Sends a one-byte status frame for every decoded
// command, or status plus four data bytes (LSB byte first) for a successful read, through
// a built-in 8N1 serializer that drives the TX pin directly.
module response_encoder #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_readwrite,
  input  logic [1:0]  i_error,
  input  logic [31:0] i_data,
  output logic        o_serial,
  output logic        o_busy,
  output logic        o_done,
  output logic [2:0]  o_state
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3,
    StNext  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [2:0]        byte_idx_q, byte_idx_d;
  logic              readwrite_q, readwrite_d;
  logic [1:0]        error_q, error_d;
  logic [31:0]       data_q, data_d;
  logic              serial_q, serial_d;
  logic              done_q, done_d;

  logic [7:0]        cur_byte;
  logic [2:0]        last_idx;
  logic              baud_end;
  logic [2:0]        bit_next;

  assign baud_end = (baud_q == BaudLast);
  assign bit_next = bit_q + 3'd1;
  // Only a successful read carries the four data bytes.
  assign last_idx = (readwrite_q && (error_q == 2'b00)) ? 3'd4 : 3'd0;

  // Select the byte currently on the wire: status first, then data LSB byte first.
  always_comb begin
    cur_byte = {4'hA, 1'b0, readwrite_q, error_q};
    case (byte_idx_q)
      3'd1:    cur_byte = data_q[7:0];
      3'd2:    cur_byte = data_q[15:8];
      3'd3:    cur_byte = data_q[23:16];
      3'd4:    cur_byte = data_q[31:24];
      default: cur_byte = {4'hA, 1'b0, readwrite_q, error_q};
    endcase
  end

  // Next-state logic; the serial line value is computed one cycle ahead so it is registered.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    byte_idx_d  = byte_idx_q;
    readwrite_d = readwrite_q;
    error_d     = error_q;
    data_d      = data_q;
    serial_d    = serial_q;
    done_d      = 1'b0;

    case (state_q)
      StIdle: begin
        serial_d = 1'b1;
        if (i_start) begin
          readwrite_d = i_readwrite;
          error_d     = i_error;
          data_d      = i_data;
          byte_idx_d  = 3'd0;
          bit_d       = 3'd0;
          baud_d      = '0;
          serial_d    = 1'b0;
          state_d     = StStart;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d   = '0;
          bit_d    = 3'd0;
          serial_d = cur_byte[0];
          state_d  = StData;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            serial_d = 1'b1;
            state_d  = StStop;
          end else begin
            bit_d    = bit_next;
            serial_d = cur_byte[bit_next];
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_idx_q < last_idx) begin
            // Next byte follows immediately, no idle gap between frames' bytes.
            byte_idx_d = byte_idx_q + 3'd1;
            serial_d   = 1'b0;
            state_d    = StStart;
          end else begin
            serial_d = 1'b1;
            done_d   = 1'b1;
            state_d  = StIdle;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: begin
        // StNext and any illegal encoding recover to idle with the line released.
        baud_d   = '0;
        bit_d    = 3'd0;
        serial_d = 1'b1;
        state_d  = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset releases the line high immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      baud_q      <= '0;
      bit_q       <= 3'd0;
      byte_idx_q  <= 3'd0;
      readwrite_q <= 1'b0;
      error_q     <= 2'b00;
      data_q      <= 32'd0;
      serial_q    <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      byte_idx_q  <= byte_idx_d;
      readwrite_q <= readwrite_d;
      error_q     <= error_d;
      data_q      <= data_d;
      serial_q    <= serial_d;
      done_q      <= done_d;
    end
  end

  assign o_serial = serial_q;
  assign o_done   = done_q;
  assign o_busy   = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
  assign o_state  = state_q;

endmodule

// File: tb/tb_response_encoder.sv
// Randomized self-checking bench for response_encoder. A reference model builds the
// expected byte list from the frame rules; a mid-bit sampler decodes the TX line.
module tb_response_encoder;

  logic        clk;
  logic        reset;
  logic        start4, start87;
  logic        rw;
  logic [1:0]  err;
  logic [31:0] data;
  logic        ser4, busy4, done4;
  logic [2:0]  state4;
  logic        ser87, busy87, done87;
  logic [2:0]  state87;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_b [0:4];

  response_encoder #(.CLKS_PER_BIT(4)) u_dut4 (
    .clock(clk), .reset(reset), .i_start(start4), .i_readwrite(rw), .i_error(err),
    .i_data(data), .o_serial(ser4), .o_busy(busy4), .o_done(done4), .o_state(state4)
  );

  response_encoder #(.CLKS_PER_BIT(87)) u_dut87 (
    .clock(clk), .reset(reset), .i_start(start87), .i_readwrite(rw), .i_error(err),
    .i_data(data), .o_serial(ser87), .o_busy(busy87), .o_done(done87), .o_state(state87)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic get_ser(input bit use87);
    return use87 ? ser87 : ser4;
  endfunction
  function automatic logic get_busy(input bit use87);
    return use87 ? busy87 : busy4;
  endfunction
  function automatic logic get_done(input bit use87);
    return use87 ? done87 : done4;
  endfunction
  function automatic logic [2:0] get_state(input bit use87);
    return use87 ? state87 : state4;
  endfunction

  task automatic set_start(input bit use87, input logic v);
    if (use87) start87 = v;
    else start4 = v;
  endtask

  // Reference: status = 0xA0 + 4*rw + err; a successful read appends data bytes LSB first.
  task automatic model(input logic r, input logic [1:0] e, input logic [31:0] d,
                       output int n);
    exp_b[0] = 8'(32'd160 + (r ? 32'd4 : 32'd0) + 32'(e));
    for (int k = 1; k < 5; k++) exp_b[k] = 8'((d >> (8 * (k - 1))) & 32'hFF);
    n = (r && e == 2'b00) ? 5 : 1;
  endtask

  // Present inputs with i_start for one accept edge; returns 1 time unit into T1.
  task automatic launch(input bit use87, input logic r, input logic [1:0] e,
                        input logic [31:0] d, input bit keep);
    @(posedge clk); #1;
    rw = r; err = e; data = d;
    set_start(use87, 1'b1);
    @(posedge clk); #1;
    if (!keep) begin
      set_start(use87, 1'b0);
      rw   = 1'($urandom_range(1, 0));
      err  = 2'($urandom_range(3, 0));
      data = $urandom;
    end
  endtask

  // Follow one frame from T1 to its o_done cycle, decoding the line at mid-bit.
  task automatic watch(input bit use87, input logic r, input logic [1:0] e,
                       input logic [31:0] d, input bit disturb, input string tag);
    int cpb, n, total, busy_bad, done_bad, poke;
    logic bits[$];
    logic [7:0] got;
    cpb = use87 ? 87 : 4;
    model(r, e, d, n);
    total = n * 10 * cpb;
    poke = disturb ? int'($urandom_range(total - 3, 1)) : -10;
    busy_bad = 0;
    done_bad = 0;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check({tag, "_t1_serial"}, 32'(get_ser(use87)), 32'd0);
        check({tag, "_t1_state"}, 32'(get_state(use87)), 32'd1);
      end
      if (!get_busy(use87)) busy_bad++;
      if (get_done(use87)) done_bad++;
      if (c % cpb == cpb / 2) bits.push_back(get_ser(use87));
      if (c == poke) begin
        set_start(use87, 1'b1);
        data = 32'd0;
      end else if (c == poke + 1) begin
        set_start(use87, 1'b0);
      end
    end
    @(negedge clk);
    check({tag, "_done"}, 32'(get_done(use87)), 32'd1);
    check({tag, "_busy_end"}, 32'(get_busy(use87)), 32'd0);
    check({tag, "_serial_end"}, 32'(get_ser(use87)), 32'd1);
    check({tag, "_state_end"}, 32'(get_state(use87)), 32'd0);
    check({tag, "_busy_hold"}, 32'(busy_bad), 32'd0);
    check({tag, "_done_early"}, 32'(done_bad), 32'd0);
    check({tag, "_nbits"}, 32'(bits.size()), 32'(n * 10));
    if (bits.size() == n * 10) begin
      for (int k = 0; k < n; k++) begin
        for (int j = 0; j < 8; j++) got[j] = bits[10 * k + 1 + j];
        check($sformatf("%s_b%0d_start", tag, k), 32'(bits[10 * k]), 32'd0);
        check($sformatf("%s_b%0d_stop", tag, k), 32'(bits[10 * k + 9]), 32'd1);
        check($sformatf("%s_b%0d", tag, k), 32'(got), 32'(exp_b[k]));
      end
    end
  endtask

  // One cycle after o_done the pulse must be gone and the line idle high.
  task automatic check_quiet(input bit use87, input string tag);
    @(negedge clk);
    check({tag, "_done_single"}, 32'(get_done(use87)), 32'd0);
    check({tag, "_line_idle"}, 32'(get_ser(use87)), 32'd1);
  endtask

  task automatic frame(input bit use87, input logic r, input logic [1:0] e,
                       input logic [31:0] d, input bit disturb, input string tag);
    launch(use87, r, e, d, 1'b0);
    watch(use87, r, e, d, disturb, tag);
    check_quiet(use87, tag);
  endtask

  initial begin
    int done_seen;
    logic        r;
    logic [1:0]  e;
    logic [31:0] d;

    reset = 1'b1; start4 = 1'b0; start87 = 1'b0; rw = 1'b0; err = 2'b00; data = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_serial", 32'(ser4), 32'd1);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    check("rst_state", 32'(state4), 32'd0);
    check("rst_serial87", 32'(ser87), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed frames: read ok with a mid-frame start/data poke, write ok, error codes.
    frame(1'b0, 1'b1, 2'b00, 32'hDEADBEEF, 1'b1, "read_ok");
    frame(1'b0, 1'b0, 2'b00, 32'h0BADF00D, 1'b0, "write_ok");
    frame(1'b0, 1'b1, 2'b11, 32'h12345678, 1'b0, "err11_rd");
    frame(1'b0, 1'b0, 2'b01, 32'hCAFEF00D, 1'b0, "err01_wr");

    // Reset during bit 3 of the first data byte.
    launch(1'b0, 1'b1, 2'b00, 32'hDEADBEEF, 1'b0);
    for (int c = 0; c <= 10 * 4 + 4 * 4 + 1; c++) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_serial", 32'(ser4), 32'd1);
    check("midrst_busy", 32'(busy4), 32'd0);
    check("midrst_state", 32'(state4), 32'd0);
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done4) done_seen++;
    end
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done4) done_seen++;
    end
    check("midrst_no_done", 32'(done_seen), 32'd0);
    frame(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, "post_rst");

    // Back-to-back: i_start held through the o_done cycle of a write ack.
    launch(1'b0, 1'b0, 2'b00, 32'h55AA55AA, 1'b1);
    watch(1'b0, 1'b0, 2'b00, 32'h55AA55AA, 1'b0, "b2b_first");
    @(posedge clk); #1;
    start4 = 1'b0;
    watch(1'b0, 1'b0, 2'b00, 32'h55AA55AA, 1'b0, "b2b_second");
    check_quiet(1'b0, "b2b_second");

    // Randomized frames, biased towards successful reads.
    for (int i = 0; i < 12; i++) begin
      r = 1'($urandom_range(1, 0));
      e = ($urandom_range(1, 0) == 1) ? 2'b00 : 2'($urandom_range(3, 0));
      d = $urandom;
      frame(1'b0, r, e, d, 1'($urandom_range(1, 0)), $sformatf("rnd%0d", i));
    end

    // Full-rate baud divider.
    frame(1'b1, 1'b0, 2'b00, 32'h0, 1'b0, "baud87_wr");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
